// File: rtl/comp_mult_cfg_seq_pkg.sv
// rtl/comp_mult_cfg_seq_pkg.sv - register offsets, FSM states and completion codes for the config sequencer
package comp_mult_cfg_seq_pkg;

  localparam logic [2:0] RF_OFS_OP1   = 3'd0;
  localparam logic [2:0] RF_OFS_OP2   = 3'd1;
  localparam logic [2:0] RF_OFS_RES   = 3'd2;
  localparam logic [2:0] RF_OFS_NOOP  = 3'd3;
  localparam logic [2:0] RF_OFS_START = 3'd4;
  localparam logic [2:0] RF_OFS_STS   = 3'd5;

  localparam logic [2:0] CFG_LAST_IDX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_CFG = 2'd1,
    ST_POLL   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DONE_OK   = 2'd0,
    DONE_ZERO = 2'd1,
    DONE_TMO  = 2'd2,
    DONE_RSVD = 2'd3
  } done_code_e;

  // Write sequence: clear status first so a stale done bit cannot end the poll early.
  function automatic logic [2:0] cfg_ofs(input logic [2:0] idx);
    case (idx)
      3'd0:    return RF_OFS_STS;
      3'd1:    return RF_OFS_OP1;
      3'd2:    return RF_OFS_OP2;
      3'd3:    return RF_OFS_RES;
      3'd4:    return RF_OFS_NOOP;
      default: return RF_OFS_START;
    endcase
  endfunction

endpackage

// File: rtl/comp_mult_cfg_seq_if.sv
// rtl/comp_mult_cfg_seq_if.sv - job, register-file and completion signals of the config sequencer
interface comp_mult_cfg_seq_if #(
  parameter int unsigned SYS_AW = 32,
  parameter int unsigned REG_DW = 32,
  parameter int unsigned CNT_W  = 16
) ();

  logic              cmd_val;
  logic              cmd_rdy;
  logic [REG_DW-1:0] cmd_op1_addr;
  logic [REG_DW-1:0] cmd_op2_addr;
  logic [REG_DW-1:0] cmd_res_addr;
  logic [REG_DW-1:0] cmd_no_op;

  logic [SYS_AW-1:0] rf_addr;
  logic              rf_wr;
  logic [REG_DW-1:0] rf_cfg;
  logic [REG_DW-1:0] rf_sts;

  logic              done_val;
  logic              done_rdy;
  logic [1:0]        done_code;
  logic [CNT_W-1:0]  done_cycles;

  modport master (
    input  cmd_val, cmd_op1_addr, cmd_op2_addr, cmd_res_addr, cmd_no_op,
    input  rf_sts, done_rdy,
    output cmd_rdy, rf_addr, rf_wr, rf_cfg,
    output done_val, done_code, done_cycles
  );

  modport slave (
    output cmd_val, cmd_op1_addr, cmd_op2_addr, cmd_res_addr, cmd_no_op,
    output rf_sts, done_rdy,
    input  cmd_rdy, rf_addr, rf_wr, rf_cfg,
    input  done_val, done_code, done_cycles
  );

endinterface

// File: rtl/comp_mult_sat_cnt.sv
// rtl/comp_mult_sat_cnt.sv - saturating up-counter with synchronous clear and count enable
module comp_mult_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/comp_mult_cfg_seq.sv
// rtl/comp_mult_cfg_seq.sv - programs, starts and polls the complex multiplier register file per job
// Optional poll timeout with start clear: define CFG_SEQ_TIMEOUT_EN.
module comp_mult_cfg_seq
  import comp_mult_cfg_seq_pkg::*;
#(
  parameter int unsigned       SYS_AW      = 32,
  parameter logic [SYS_AW-1:0] RF_BADDR    = '0,
  parameter int unsigned       REG_DW      = 32,
  parameter int unsigned       CNT_W       = 16,
  parameter int unsigned       TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_rst,
  comp_mult_cfg_seq_if.master bus
);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d, nxt_idx;
  logic [REG_DW-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d, no_op_q, no_op_d;
  logic              rf_wr_q, rf_wr_d;
  logic [SYS_AW-1:0] rf_addr_q, rf_addr_d;
  logic [REG_DW-1:0] rf_cfg_q, rf_cfg_d, cfg_data;
  done_code_e        done_code_q, done_code_d;
  logic              accept, in_poll;
  logic [CNT_W-1:0]  cyc_cnt;
  logic              sts_unused;

  function automatic logic [SYS_AW-1:0] rf_at(input logic [2:0] ofs);
    return RF_BADDR + SYS_AW'(ofs);
  endfunction

  assign accept     = (state_q == ST_IDLE) && bus.cmd_val;
  assign in_poll    = (state_q == ST_POLL);
  assign nxt_idx    = idx_q + 3'd1;
  assign sts_unused = ^bus.rf_sts[REG_DW-1:1];

  comp_mult_sat_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sw_rst | accept),
    .en_i  (in_poll),
    .cnt_o (cyc_cnt)
  );

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  comp_mult_sat_cnt #(.W(TMO_W)) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sw_rst | accept),
    .en_i  (in_poll),
    .cnt_o (tmo_cnt)
  );

  // tmo_cnt holds the polls already completed, so this fires on the TIMEOUT_CYC-th sample.
  assign tmo_hit = in_poll && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  localparam int unsigned TMO_CYC_UNUSED = TIMEOUT_CYC;
`endif

  always_comb begin
    cfg_data = '0;
    case (nxt_idx)
      3'd1:    cfg_data = op1_q;
      3'd2:    cfg_data = op2_q;
      3'd3:    cfg_data = res_q;
      3'd4:    cfg_data = no_op_q;
      3'd5:    cfg_data = REG_DW'(1);
      default: cfg_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    res_d       = res_q;
    no_op_d     = no_op_q;
    rf_wr_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_cfg_d    = rf_cfg_q;
    done_code_d = done_code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op1_d   = bus.cmd_op1_addr;
          op2_d   = bus.cmd_op2_addr;
          res_d   = bus.cmd_res_addr;
          no_op_d = bus.cmd_no_op;
          idx_d   = 3'd0;
          state_d = ST_WR_CFG;
          // A zero-count job passes through WR_CFG silently and is rejected there.
          if (bus.cmd_no_op != '0) begin
            rf_wr_d   = 1'b1;
            rf_addr_d = rf_at(cfg_ofs(3'd0));
            rf_cfg_d  = '0;
          end
        end
      end
      ST_WR_CFG: begin
        if (no_op_q == '0) begin
          state_d     = ST_DONE;
          done_code_d = DONE_ZERO;
        end else if (idx_q == CFG_LAST_IDX) begin
          state_d   = ST_POLL;
          rf_addr_d = rf_at(RF_OFS_STS);
        end else begin
          idx_d     = nxt_idx;
          rf_wr_d   = 1'b1;
          rf_addr_d = rf_at(cfg_ofs(nxt_idx));
          rf_cfg_d  = cfg_data;
        end
      end
      ST_POLL: begin
        if (bus.rf_sts[0]) begin
          state_d     = ST_DONE;
          done_code_d = DONE_OK;
        end
`ifdef CFG_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d     = ST_DONE;
          done_code_d = DONE_TMO;
          rf_wr_d     = 1'b1;
          rf_addr_d   = rf_at(RF_OFS_START);
          rf_cfg_d    = '0;
        end
`endif
      end
      ST_DONE: begin
        if (bus.done_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      no_op_q     <= '0;
      rf_wr_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_cfg_q    <= '0;
      done_code_q <= DONE_OK;
    end else if (sw_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      no_op_q     <= '0;
      rf_wr_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_cfg_q    <= '0;
      done_code_q <= DONE_OK;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_q       <= res_d;
      no_op_q     <= no_op_d;
      rf_wr_q     <= rf_wr_d;
      rf_addr_q   <= rf_addr_d;
      rf_cfg_q    <= rf_cfg_d;
      done_code_q <= done_code_d;
    end
  end

  assign bus.cmd_rdy     = (state_q == ST_IDLE);
  assign bus.rf_wr       = rf_wr_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_cfg      = rf_cfg_q;
  assign bus.done_val    = (state_q == ST_DONE);
  assign bus.done_code   = done_code_q;
  assign bus.done_cycles = cyc_cnt;

endmodule

// File: tb/tb_comp_mult_cfg_seq.sv
// tb/tb_comp_mult_cfg_seq.sv - randomized scoreboard bench for comp_mult_cfg_seq
module tb_comp_mult_cfg_seq;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 8;
  localparam logic [AW-1:0] BASE = 32'h100;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;
`ifdef CFG_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int code;
    int cycles;
    int lat;
  } done_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sw_rst = 1'b0;
  always #5 clk = ~clk;

  comp_mult_cfg_seq_if #(.SYS_AW(AW), .REG_DW(DW), .CNT_W(CW)) bus ();

  comp_mult_cfg_seq #(
    .SYS_AW(AW), .RF_BADDR(BASE), .REG_DW(DW), .CNT_W(CW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int target = 1;
  int poll_k = 0;
  bit armed = 1'b0;
  bit dv_prev = 1'b0;
  logic [DW-1:0] sts_rnd;
  wr_t   exp_wr[$];
  done_t exp_done[$];
  done_t cur_done;
  wr_t   got_w;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input longint unsigned act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got 0x%0h, required no such event", nm, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor
  always @(negedge clk) begin
    if (rst_n && bus.rf_wr) begin
      if (exp_wr.size() == 0) begin
        fail_now("unexpected_wr", 64'(bus.rf_addr));
      end else begin
        got_w = exp_wr.pop_front();
        chk("wr_addr", 64'(bus.rf_addr), 64'(got_w.addr));
        chk("wr_data", 64'(bus.rf_cfg), 64'(got_w.data));
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (rst_n && bus.done_val) begin
      if (!dv_prev) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done", 64'(bus.done_code));
        end else begin
          cur_done = exp_done.pop_front();
          chk("done_code", 64'(bus.done_code), 64'(cur_done.code));
          chk("done_cycles", 64'(bus.done_cycles), 64'(cur_done.cycles));
          chk("done_latency", 64'(cyc - accept_cyc), 64'(cur_done.lat));
        end
      end else begin
        chk("done_code_hold", 64'(bus.done_code), 64'(cur_done.code));
        chk("done_cycles_hold", 64'(bus.done_cycles), 64'(cur_done.cycles));
      end
    end
    dv_prev = bus.done_val;
  end

  // Status model: done bit rises on the target-th poll; outside polling bit0 is noise
  always @(negedge clk) begin
    if (!rst_n || sw_rst || bus.done_val) begin
      armed  = 1'b0;
      poll_k = 0;
    end else if (armed) begin
      poll_k++;
      chk("poll_rf_wr", 64'(bus.rf_wr), 64'(0));
      chk("poll_addr", 64'(bus.rf_addr), 64'(BASE + 32'd5));
    end
    if (bus.rf_wr && bus.rf_addr == BASE + 32'd4 && bus.rf_cfg == 32'd1) begin
      armed  = 1'b1;
      poll_k = 0;
    end
    sts_rnd = $urandom();
    if (armed) sts_rnd[0] = (poll_k >= target);
    bus.rf_sts = sts_rnd;
  end

  task automatic issue_job(input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                           input logic [DW-1:0] res, input logic [DW-1:0] no,
                           input int tgt, input bit abort);
    int ofs[6];
    logic [DW-1:0] dat[6];
    wr_t w;
    done_t d;
    int polls;
    int n;
    bit tmo;
    ofs = '{5, 0, 1, 2, 3, 4};
    dat[0] = '0; dat[1] = op1; dat[2] = op2; dat[3] = res; dat[4] = no; dat[5] = 32'd1;
    target = tgt;
    tmo = TMO_EN && (tgt > int'(TMO));
    if (no != '0) begin
      for (int i = 0; i < (abort ? 3 : 6); i++) begin
        w.addr = BASE + AW'(ofs[i]);
        w.data = dat[i];
        exp_wr.push_back(w);
      end
      polls = tmo ? int'(TMO) : tgt;
      if (tmo && !abort) begin
        w.addr = BASE + 32'd4;
        w.data = '0;
        exp_wr.push_back(w);
      end
      d.code   = tmo ? 2 : 0;
      d.cycles = (polls > int'(CNT_MAX)) ? int'(CNT_MAX) : polls;
      d.lat    = 6 + polls;
    end else begin
      d.code   = 1;
      d.cycles = 0;
      d.lat    = 1;
    end
    if (!abort) exp_done.push_back(d);
    bus.cmd_op1_addr = op1;
    bus.cmd_op2_addr = op2;
    bus.cmd_res_addr = res;
    bus.cmd_no_op    = no;
    bus.cmd_val      = 1'b1;
    n = 0;
    while (!bus.cmd_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_rdy) fail_now("accept_timeout", 64'(n));
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    // Keep cmd_val high with junk fields while busy; none of it may be taken.
    bus.cmd_op1_addr = $urandom();
    bus.cmd_op2_addr = $urandom();
    bus.cmd_res_addr = $urandom();
    bus.cmd_no_op    = $urandom();
  endtask

  task automatic wait_done(input int hold, input bit early);
    int n;
    n = 0;
    if (early) bus.done_rdy = 1'b1;
    while (!bus.done_val && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.cmd_val = 1'b0;
    if (!bus.done_val) begin
      fail_now("done_timeout", 64'(n));
      bus.done_rdy = 1'b0;
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_done_val", 64'(bus.done_val), 64'(1));
        chk("hold_cmd_rdy", 64'(bus.cmd_rdy), 64'(0));
      end
      bus.done_rdy = 1'b1;
      @(posedge clk);
      #1;
      bus.done_rdy = 1'b0;
      chk("cmd_rdy_after_done", 64'(bus.cmd_rdy), 64'(1));
      chk("done_val_cleared", 64'(bus.done_val), 64'(0));
    end
  endtask

  initial begin
    logic [DW-1:0] no;
    int tgt;
    bit early;
    bus.cmd_val      = 1'b0;
    bus.cmd_op1_addr = '0;
    bus.cmd_op2_addr = '0;
    bus.cmd_res_addr = '0;
    bus.cmd_no_op    = '0;
    bus.done_rdy     = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'(1));
    chk("rst_rf_wr", 64'(bus.rf_wr), 64'(0));
    chk("rst_done_val", 64'(bus.done_val), 64'(0));
    chk("rst_rf_addr", 64'(bus.rf_addr), 64'(0));
    chk("rst_rf_cfg", 64'(bus.rf_cfg), 64'(0));
    chk("rst_done_code", 64'(bus.done_code), 64'(0));
    chk("rst_done_cycles", 64'(bus.done_cycles), 64'(0));

    issue_job(32'h10, 32'h20, 32'h40, 32'd2, 5, 1'b0);
    wait_done(0, 1'b0);

    issue_job($urandom(), $urandom(), $urandom(), 32'd0, 3, 1'b0);
    wait_done(0, 1'b0);

    issue_job($urandom(), $urandom(), $urandom(), 32'd3, 4, 1'b0);
    wait_done(10, 1'b0);

    // sw_rst while the third configuration write is on the bus
    issue_job($urandom(), $urandom(), $urandom(), 32'd7, 3, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.cmd_val = 1'b0;
    sw_rst = 1'b1;
    @(posedge clk);
    #1;
    sw_rst = 1'b0;
    chk("abort_rf_wr", 64'(bus.rf_wr), 64'(0));
    chk("abort_cmd_rdy", 64'(bus.cmd_rdy), 64'(1));
    chk("abort_done_val", 64'(bus.done_val), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(bus.done_val), 64'(0));
    chk("abort_wr_drained", 64'(exp_wr.size()), 64'(0));

    issue_job(32'hA5A5_0001, 32'h5A5A_0002, 32'hFFFF_FFF0, 32'd4, 2, 1'b0);
    wait_done(0, 1'b1);

    issue_job($urandom(), $urandom(), $urandom(), 32'd9, 20, 1'b0);
    wait_done(2, 1'b0);

    for (int k = 0; k < 16; k++) begin
      no = ($urandom_range(3) == 0) ? 32'd0 : $urandom();
      if (no == '0 && k[0]) no = 32'd1;
      tgt   = $urandom_range(20, 1);
      early = 1'($urandom_range(1));
      issue_job($urandom(), $urandom(), $urandom(), no, tgt, 1'b0);
      wait_done(early ? 0 : $urandom_range(4), early);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("end_wr_queue", 64'(exp_wr.size()), 64'(0));
    chk("end_done_queue", 64'(exp_done.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
